// File: rtl/queue_pkg.sv
// Shared constants and FSM encoding for the packet
// queue read side.
package queue_pkg;

   localparam int DATA_W  = 64;
   localparam int INNER_W = 8;
   localparam int OUTER_W = 2;
   localparam int NUM_SEG = 1 << OUTER_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } rd_state_e;

endpackage

// File: rtl/queue_rd_skid.sv
// Two-entry skid FIFO between the queue RAM read port
// and the downstream valid/ready interface.
module queue_rd_skid #(
   parameter int W = 65
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_rdy,
   output logic [1:0]   count
);

   logic [W-1:0] buf_q [2];
   logic         rd_ptr;
   logic         wr_ptr;
   logic         push;
   logic         pop;

   assign push      = in_valid;
   assign pop       = out_valid & out_rdy;
   assign out_valid = (count != 2'd0);
   assign out_data  = buf_q[rd_ptr];

   // Upstream credit accounting guarantees push never hits a full buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            buf_q[wr_ptr] <= in_data;
            wr_ptr        <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: rtl/queue_pkt_reader.sv
// Read-side engine of the 4-segment packet queue:
// drains committed segments in ring order onto a valid/ready stream.
module queue_pkt_reader
   import queue_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       seg_commit,
   input  logic [OUTER_W-1:0]         seg_commit_id,
   input  logic [INNER_W-1:0]         seg_commit_last,
   output logic [NUM_SEG-1:0]         seg_valid,
   input  logic                       queue_out_en,
   output logic                       mem_ren,
   output logic [OUTER_W+INNER_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_valid,
   input  logic                       out_rdy,
   output logic                       out_pkt_end,
   output logic                       pkt_done,
   output logic                       commit_err,
   output logic [OUTER_W-1:0]         RP_outer,
   output logic [INNER_W-1:0]         RP_inner
);

   rd_state_e          state;
   rd_state_e          state_nxt;
   logic [INNER_W-1:0] last_addr [NUM_SEG];
   logic [INNER_W-1:0] cur_last;
   logic               issue;
   logic               issue_last;
   logic               release_pkt;
   logic               fl_valid;
   logic               fl_end;
   logic [1:0]         skid_cnt;
   logic [DATA_W:0]    skid_head;
   logic               skid_pop;
   logic [2:0]         occ;
   logic               credit_ok;
   logic               commit_ok;

   assign cur_last  = last_addr[RP_outer];
   assign mem_raddr = {RP_outer, RP_inner};
   assign mem_ren   = issue;
   assign skid_pop  = out_valid & out_rdy;

   // A word leaving the skid this cycle frees its slot for a new issue.
   assign occ       = {1'b0, skid_cnt} + {2'b0, fl_valid} - {2'b0, skid_pop};
   assign credit_ok = (occ < 3'd2);

   assign out_data    = skid_head[DATA_W-1:0];
   assign out_pkt_end = out_valid & skid_head[DATA_W];

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:
            if (queue_out_en && seg_valid[RP_outer])
               state_nxt = ST_STREAM;
         ST_STREAM:
            if (issue_last)
               state_nxt = ST_DRAIN;
         ST_DRAIN:
            if (release_pkt)
               state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      issue       = 1'b0;
      issue_last  = 1'b0;
      release_pkt = 1'b0;
      unique case (state)
         ST_STREAM: begin
            issue      = credit_ok;
            issue_last = credit_ok && (RP_inner == cur_last);
         end
         ST_DRAIN:
            release_pkt = skid_pop && out_pkt_end;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         RP_outer <= '0;
         RP_inner <= '0;
         fl_valid <= 1'b0;
         fl_end   <= 1'b0;
         pkt_done <= 1'b0;
      end else begin
         fl_valid <= issue;
         fl_end   <= issue_last;
         pkt_done <= release_pkt;
         if (release_pkt) begin
            RP_outer <= RP_outer + OUTER_W'(1);
            RP_inner <= '0;
         end else if (issue) begin
            RP_inner <= RP_inner + INNER_W'(1);
         end
      end
   end

   // Committing into the segment being released this cycle is legal.
   assign commit_ok = !seg_valid[seg_commit_id] ||
                      (release_pkt && (seg_commit_id == RP_outer));

   always_ff @(posedge clk) begin
      if (reset) begin
         seg_valid  <= '0;
         commit_err <= 1'b0;
         for (int i = 0; i < NUM_SEG; i++)
            last_addr[i] <= '0;
      end else begin
         commit_err <= 1'b0;
         if (release_pkt)
            seg_valid[RP_outer] <= 1'b0;
         if (seg_commit) begin
            if (commit_ok) begin
               seg_valid[seg_commit_id] <= 1'b1;
               last_addr[seg_commit_id] <= seg_commit_last;
            end else begin
               commit_err <= 1'b1;
            end
         end
      end
   end

   queue_rd_skid #(
      .W (DATA_W + 1)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (fl_valid),
      .in_data   ({fl_end, mem_rdata}),
      .out_valid (out_valid),
      .out_data  (skid_head),
      .out_rdy   (out_rdy),
      .count     (skid_cnt)
   );

endmodule

// File: tb/tb_queue_pkt_reader.sv
// Directed bench for queue_pkt_reader with a
// behavioural 1-cycle-latency queue RAM.
module tb_queue_pkt_reader;
   import queue_pkg::*;

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       seg_commit;
   logic [OUTER_W-1:0]         seg_commit_id;
   logic [INNER_W-1:0]         seg_commit_last;
   logic [NUM_SEG-1:0]         seg_valid;
   logic                       queue_out_en;
   logic                       mem_ren;
   logic [OUTER_W+INNER_W-1:0] mem_raddr;
   logic [DATA_W-1:0]          mem_rdata;
   logic [DATA_W-1:0]          out_data;
   logic                       out_valid;
   logic                       out_rdy;
   logic                       out_pkt_end;
   logic                       pkt_done;
   logic                       commit_err;
   logic [OUTER_W-1:0]         RP_outer;
   logic [INNER_W-1:0]         RP_inner;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int stall_bad   = 0;
   int n_cyc;
   int k;

   logic [63:0] q_data [$];
   logic        q_end  [$];
   int          q_cyc  [$];
   logic [9:0]  e_addr [$];
   logic        e_end  [$];

   logic        prev_stall = 1'b0;
   logic [63:0] prev_data;
   logic        prev_end;

   queue_pkt_reader dut (
      .clk             (clk),
      .reset           (reset),
      .seg_commit      (seg_commit),
      .seg_commit_id   (seg_commit_id),
      .seg_commit_last (seg_commit_last),
      .seg_valid       (seg_valid),
      .queue_out_en    (queue_out_en),
      .mem_ren         (mem_ren),
      .mem_raddr       (mem_raddr),
      .mem_rdata       (mem_rdata),
      .out_data        (out_data),
      .out_valid       (out_valid),
      .out_rdy         (out_rdy),
      .out_pkt_end     (out_pkt_end),
      .pkt_done        (pkt_done),
      .commit_err      (commit_err),
      .RP_outer        (RP_outer),
      .RP_inner        (RP_inner)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] word_of(input logic [9:0] a);
      return {20'hD47A5, 34'h0, a};
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_ren)
         mem_rdata <= word_of(mem_raddr);
   end

   always @(negedge clk) begin
      if (out_valid && out_rdy) begin
         q_data.push_back(out_data);
         q_end.push_back(out_pkt_end);
         q_cyc.push_back(cyc);
      end
      if (prev_stall && (!out_valid || out_data !== prev_data ||
                         out_pkt_end !== prev_end))
         stall_bad <= stall_bad + 1;
      prev_stall <= out_valid && !out_rdy && !reset;
      prev_data  <= out_data;
      prev_end   <= out_pkt_end;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input int id, input int last);
      seg_commit      = 1'b1;
      seg_commit_id   = id[1:0];
      seg_commit_last = last[7:0];
   endtask

   task automatic wait_done(input int bound, input string tag);
      int n = 0;
      while (!pkt_done && n < bound) begin
         tick;
         n++;
      end
      chk(tag, pkt_done, 1);
   endtask

   task automatic clear_q;
      q_data.delete();
      q_end.delete();
      q_cyc.delete();
      e_addr.delete();
      e_end.delete();
   endtask

   task automatic push_pkt(input int seg, input int last);
      for (int i = 0; i <= last; i++) begin
         e_addr.push_back(10'(seg * 256 + i));
         e_end.push_back(i == last);
      end
   endtask

   task automatic check_stream(input string tag);
      chk({tag, "_len"}, q_data.size(), e_addr.size());
      for (int i = 0; i < q_data.size() && i < e_addr.size(); i++) begin
         chk($sformatf("%s_data%0d", tag, i), q_data[i], word_of(e_addr[i]));
         chk($sformatf("%s_end%0d", tag, i), q_end[i], e_end[i]);
      end
   endtask

   initial begin
      reset           = 1'b1;
      seg_commit      = 1'b0;
      seg_commit_id   = '0;
      seg_commit_last = '0;
      queue_out_en    = 1'b0;
      out_rdy         = 1'b0;
      tick;
      tick;
      chk("rst_seg_valid", seg_valid, 0);
      chk("rst_rp_outer", RP_outer, 0);
      chk("rst_rp_inner", RP_inner, 0);
      chk("rst_mem_ren", mem_ren, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_pkt_end", out_pkt_end, 0);
      chk("rst_pkt_done", pkt_done, 0);
      chk("rst_commit_err", commit_err, 0);
      reset = 1'b0;
      tick;

      // 4-word packet, no backpressure
      clear_q;
      push_pkt(0, 3);
      commit(0, 3);
      queue_out_en = 1'b1;
      out_rdy      = 1'b1;
      tick;
      seg_commit = 1'b0;
      n_cyc = cyc;
      chk("t1_seg_valid", seg_valid, 4'b0001);
      chk("t1_ren_idle", mem_ren, 0);
      tick;
      chk("t1_ren_first", mem_ren, 1);
      chk("t1_raddr_first", mem_raddr, 10'h000);
      chk("t1_no_early_valid", out_valid, 0);
      wait_done(40, "t1_done");
      chk("t1_seg_clear", seg_valid, 0);
      chk("t1_rp_outer", RP_outer, 1);
      chk("t1_rp_inner", RP_inner, 0);
      check_stream("t1");
      if (q_cyc.size() == 4) begin
         chk("t1_first_cyc", q_cyc[0], n_cyc + 3);
         chk("t1_last_cyc", q_cyc[3], n_cyc + 6);
      end
      tick;

      // Same packet shape with alternating backpressure
      clear_q;
      push_pkt(1, 3);
      commit(1, 3);
      tick;
      seg_commit = 1'b0;
      k = 0;
      while (!pkt_done && k < 60) begin
         out_rdy = ~out_rdy;
         tick;
         k++;
      end
      chk("t2_done", pkt_done, 1);
      out_rdy = 1'b1;
      check_stream("t2");
      chk("t2_stall_stable", stall_bad, 0);
      chk("t2_rp_outer", RP_outer, 2);
      tick;

      // Double commit to seg1, then ring wrap through 3 -> 0
      queue_out_en = 1'b0;
      clear_q;
      commit(2, 1);
      tick;
      commit(1, 5);
      tick;
      chk("t4_err_first", commit_err, 0);
      commit(1, 9);
      tick;
      chk("t4_err_pulse", commit_err, 1);
      commit(3, 0);
      tick;
      chk("t4_err_clear", commit_err, 0);
      commit(0, 0);
      tick;
      seg_commit = 1'b0;
      chk("t3_all_valid", seg_valid, 4'b1111);
      push_pkt(2, 1);
      push_pkt(3, 0);
      push_pkt(0, 0);
      push_pkt(1, 5);
      queue_out_en = 1'b1;
      for (int p = 0; p < 4; p++) begin
         wait_done(60, $sformatf("t3_done%0d", p));
         if (p == 1)
            chk("t3_wrap", RP_outer, 0);
         tick;
      end
      check_stream("t3");
      chk("t3_rp_outer", RP_outer, 2);
      chk("t3_seg_clear", seg_valid, 0);

      // Reset in the middle of a 256-word packet
      clear_q;
      commit(2, 255);
      tick;
      seg_commit = 1'b0;
      k = 0;
      while (q_data.size() < 100 && k < 400) begin
         tick;
         k++;
      end
      chk("t5_reach", q_data.size() >= 100, 1);
      reset = 1'b1;
      tick;
      chk("t5_out_valid", out_valid, 0);
      chk("t5_pkt_end", out_pkt_end, 0);
      chk("t5_mem_ren", mem_ren, 0);
      chk("t5_pkt_done", pkt_done, 0);
      chk("t5_commit_err", commit_err, 0);
      chk("t5_seg_valid", seg_valid, 0);
      chk("t5_rp_outer", RP_outer, 0);
      chk("t5_rp_inner", RP_inner, 0);
      reset = 1'b0;
      clear_q;
      repeat (6) tick;
      chk("t5_no_words", q_data.size(), 0);
      chk("t5_idle_valid", out_valid, 0);

      // Four full segments back to back
      queue_out_en = 1'b0;
      for (int s = 0; s < 4; s++) begin
         commit(s, 255);
         tick;
      end
      seg_commit = 1'b0;
      clear_q;
      for (int s = 0; s < 4; s++)
         push_pkt(s, 255);
      queue_out_en = 1'b1;
      for (int p = 0; p < 4; p++) begin
         wait_done(400, $sformatf("t6_done%0d", p));
         tick;
      end
      check_stream("t6");
      if (q_cyc.size() == 1024) begin
         for (int p = 0; p < 4; p++)
            chk($sformatf("t6_burst%0d", p),
                q_cyc[256*p+255] - q_cyc[256*p], 255);
         for (int p = 1; p < 4; p++)
            chk($sformatf("t6_gap%0d", p),
                q_cyc[256*p] - q_cyc[256*p-1], 4);
      end
      chk("t6_rp_outer", RP_outer, 0);
      chk("t6_seg_clear", seg_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
